// File: rtl/uwasic_onboarding_nikhil_doal_pkg.sv
// Shared constants for the SPI-controlled output tile: register map,
// PWM prescale and SPI frame geometry.
package uwasic_onboarding_nikhil_doal_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int NUM_REGS = 5;

    // clk cycles per PWM counter tick; 13 x 256 = 3328 clk per PWM period
    localparam int PRESCALE = 13;
    localparam int PRE_W    = $clog2(PRESCALE);

    // one write frame: R/W bit, 7-bit address, 8-bit data
    localparam int FRAME_W  = 16;
    // bit counter must reach FRAME_W + 1 so an over-long frame is distinguishable
    localparam int BITCNT_W = $clog2(FRAME_W + 2);

endpackage

// File: rtl/uwasic_onboarding_nikhil_doal_pwm_peripheral.sv
// Shared PWM generator and per-output mux (off / high / PWM).
module pwm_peripheral
    import uwasic_onboarding_nikhil_doal_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  duty,
    input  logic [15:0] en_out,
    input  logic [15:0] en_pwm,
    output logic [15:0] out
);

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       pwm_cnt;
    logic             pwm;

    // prescaler wraps every PRESCALE clk and advances the 8-bit PWM counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (pre_cnt == PRE_W'(PRESCALE - 1)) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // duty 0xFF is treated as fully on rather than 255/256
    always_comb begin
        pwm = (duty == 8'hFF) || (pwm_cnt < duty);
    end

    // disabled outputs stay low; enabled ones are high or follow the PWM
    always_comb begin
        out = en_out & (~en_pwm | {16{pwm}});
    end

endmodule

// File: rtl/uwasic_onboarding_nikhil_doal.sv
// Tile top: synchronized write-only SPI receiver, 5-entry register file and
// the PWM output block.
module uwasic_onboarding_nikhil_doal
    import uwasic_onboarding_nikhil_doal_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,     // active-high despite the name
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic rst;
    assign rst = rst_n;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

    // bit order inside the sync vectors: [0]=SCLK, [1]=COPI, [2]=nCS
    logic [2:0] sync_a, sync_b, sync_prev;
    logic       sclk_s, copi_s, ncs_s;
    logic       sclk_rise, ncs_fall, ncs_rise;

    logic [FRAME_W-1:0]  shift_reg;
    logic [BITCNT_W-1:0] bit_cnt;
    logic                commit_pend;
    logic [6:0]          commit_addr;
    logic [7:0]          commit_data;

    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out_bus;

    // two-flop synchronizer plus one delay stage for edge detection; nCS idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a    <= 3'b100;
            sync_b    <= 3'b100;
            sync_prev <= 3'b100;
        end else begin
            sync_a    <= ui_in[2:0];
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    assign sclk_s    = sync_b[0];
    assign copi_s    = sync_b[1];
    assign ncs_s     = sync_b[2];
    assign sclk_rise = sclk_s & ~sync_prev[0];
    assign ncs_fall  = ~ncs_s & sync_prev[2];
    assign ncs_rise  = ncs_s & ~sync_prev[2];

    // shift in COPI on SCLK rise; count saturates one past a full frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (sclk_rise && !ncs_s) begin
            if (bit_cnt < BITCNT_W'(FRAME_W)) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], copi_s};
                bit_cnt   <= bit_cnt + 1'b1;
            end else begin
                bit_cnt   <= BITCNT_W'(FRAME_W + 1);
            end
        end
    end

    // qualify the frame at nCS rise; the register write happens one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_pend <= 1'b0;
            commit_addr <= '0;
            commit_data <= '0;
        end else begin
            commit_pend <= ncs_rise && (bit_cnt == BITCNT_W'(FRAME_W)) &&
                           shift_reg[15] && (shift_reg[14:8] <= ADDR_DUTY);
            commit_addr <= shift_reg[14:8];
            commit_data <= shift_reg[7:0];
        end
    end

    // register file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out <= '0;
            en_pwm <= '0;
            duty   <= '0;
        end else if (commit_pend) begin
            case (commit_addr)
                ADDR_EN_OUT_LO: en_out[7:0]  <= commit_data;
                ADDR_EN_OUT_HI: en_out[15:8] <= commit_data;
                ADDR_EN_PWM_LO: en_pwm[7:0]  <= commit_data;
                ADDR_EN_PWM_HI: en_pwm[15:8] <= commit_data;
                ADDR_DUTY:      duty         <= commit_data;
                default: ;
            endcase
        end
    end

    pwm_peripheral u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty   (duty),
        .en_out (en_out),
        .en_pwm (en_pwm),
        .out    (out_bus)
    );

    assign uo_out  = out_bus[7:0];
    assign uio_out = out_bus[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_nikhil_doal.sv
module tb_uwasic_onboarding_nikhil_doal;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       sclk, copi, ncs;

    int checks   = 0;
    int failures = 0;

    // behavioural register image: 0/1 en_out, 2/3 en_pwm, 4 duty
    logic [7:0] m_regs [5];

    always #50 clk = ~clk;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    uwasic_onboarding_nikhil_doal dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    endfunction

    // host-side view: a frame takes effect only if it is a complete 16-bit write in range
    function automatic void model_frame(input logic [31:0] bits, input int nbits);
        logic [15:0] f;
        int          a;
        f = bits[15:0];
        a = int'(f[14:8]);
        if (nbits == 16 && f[15] && a <= 4) m_regs[a] = f[7:0];
    endfunction

    // expected 16 outputs; PWM-driven bits only definite when duty is 0 or 0xFF
    function automatic logic [15:0] exp_out();
        logic [15:0] r;
        logic [15:0] eo, ep;
        eo = {m_regs[1], m_regs[0]};
        ep = {m_regs[3], m_regs[2]};
        for (int i = 0; i < 16; i++)
            r[i] = !eo[i] ? 1'b0 : (!ep[i] ? 1'b1 : (m_regs[4] == 8'hFF));
        return r;
    endfunction

    function automatic logic [15:0] exp_mask();
        if (m_regs[4] == 8'h00 || m_regs[4] == 8'hFF) return 16'hFFFF;
        return ~({m_regs[1], m_regs[0]} & {m_regs[3], m_regs[2]});
    endfunction

    // SCLK half period of 4 clk (clk/8), MSB first, leaves nCS low
    task automatic spi_bits(input logic [31:0] bits, input int nbits);
        ncs = 1'b0;
        wait_clk(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = bits[i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
    endtask

    task automatic spi_end();
        ncs  = 1'b1;
        copi = 1'b0;
        wait_clk(8);
    endtask

    task automatic spi_frame(input logic [31:0] bits, input int nbits);
        spi_bits(bits, nbits);
        spi_end();
        model_frame(bits, nbits);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        wait_clk(5);
        checks++;
        if (uo_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_uo_out got=%h want=00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_uio_out got=%h want=00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'hFF) begin
            failures++;
            $display("FAIL reset_uio_oe got=%h want=FF", uio_oe);
        end
        rst_n = 1'b0;
        model_reset();
        wait_clk(4);
    endtask

    task automatic test_basic_write();
        spi_frame(32'h80F0, 16);
        spi_frame(32'h81CC, 16);
        checks++;
        if (uo_out !== 8'hF0) begin
            failures++;
            $display("FAIL basic_uo_out got=%h want=F0", uo_out);
        end
        checks++;
        if (uio_out !== 8'hCC) begin
            failures++;
            $display("FAIL basic_uio_out got=%h want=CC", uio_out);
        end
    endtask

    task automatic test_read_and_bad_addr();
        spi_frame(32'h00AA, 16);   // read of reg 0
        spi_frame(32'h30AA, 16);   // read of address 0x30
        spi_frame(32'hB055, 16);   // write to 0x30
        spi_frame(32'h8555, 16);   // write to 0x05, just past the map
        checks++;
        if ({uio_out, uo_out} !== 16'hCCF0) begin
            failures++;
            $display("FAIL read_badaddr got=%h want=CCF0", {uio_out, uo_out});
        end
    endtask

    task automatic test_pwm_half();
        int cyc, high, period;
        logic prev, found;
        spi_frame(32'h8001, 16);
        spi_frame(32'h8100, 16);
        spi_frame(32'h8201, 16);
        spi_frame(32'h8300, 16);
        spi_frame(32'h8480, 16);
        // expected: 256 ticks x 13 clk period, 128 ticks x 13 clk high
        found = 1'b0;
        prev  = uo_out[0];
        for (cyc = 0; cyc < 5000 && !found; cyc++) begin
            wait_clk(1);
            if (uo_out[0] && !prev) found = 1'b1;
            prev = uo_out[0];
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL pwm_first_edge got=none want=rising_edge_within_5000");
        end else begin
            high   = 1;
            period = 0;
            found  = 1'b0;
            for (cyc = 1; cyc < 5000 && !found; cyc++) begin
                wait_clk(1);
                if (uo_out[0] && !prev) begin
                    found  = 1'b1;
                    period = cyc;
                end else if (uo_out[0]) begin
                    high++;
                end
                prev = uo_out[0];
            end
            checks++;
            if (period != 3328) begin
                failures++;
                $display("FAIL pwm_period got=%0d want=3328", period);
            end
            checks++;
            if (high != 128 * 13) begin
                failures++;
                $display("FAIL pwm_high_time got=%0d want=%0d", high, 128 * 13);
            end
        end
    endtask

    task automatic test_pwm_extremes();
        int ones;
        spi_frame(32'h8400, 16);
        ones = 0;
        for (int i = 0; i < 3400; i++) begin
            wait_clk(1);
            if (uo_out[0]) ones++;
        end
        checks++;
        if (ones != 0) begin
            failures++;
            $display("FAIL pwm_duty00 got_high_cycles=%0d want=0", ones);
        end
        spi_frame(32'h84FF, 16);
        ones = 0;
        for (int i = 0; i < 3400; i++) begin
            wait_clk(1);
            if (uo_out[0]) ones++;
        end
        checks++;
        if (ones != 3400) begin
            failures++;
            $display("FAIL pwm_dutyFF got_high_cycles=%0d want=3400", ones);
        end
    endtask

    task automatic test_abort_and_overrun();
        logic [15:0] e;
        spi_frame(32'h0000_0080, 8);            // first byte of 0x8055, then nCS up
        spi_frame({15'd0, 16'h8055, 1'b1}, 17); // 17-bit frame
        e = exp_out();
        checks++;
        if ({uio_out, uo_out} !== e) begin
            failures++;
            $display("FAIL abort_overrun got=%h want=%h", {uio_out, uo_out}, e);
        end
        spi_frame(32'h8103, 16);
        e = exp_out();
        checks++;
        if ({uio_out, uo_out} !== e) begin
            failures++;
            $display("FAIL after_abort_valid got=%h want=%h", {uio_out, uo_out}, e);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] e;
        spi_bits(32'h0000_0080, 8);
        rst_n = 1'b1;
        wait_clk(5);
        rst_n = 1'b0;
        model_reset();
        spi_bits(32'h0000_0055, 8);
        spi_end();
        checks++;
        if ({uio_out, uo_out} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_frame got=%h want=0000", {uio_out, uo_out});
        end
        spi_frame(32'h800F, 16);
        e = exp_out();
        checks++;
        if ({uio_out, uo_out} !== e) begin
            failures++;
            $display("FAIL post_reset_write got=%h want=%h", {uio_out, uo_out}, e);
        end
    endtask

    task automatic test_random_frames();
        logic [15:0] f, e, m;
        logic [31:0] bits;
        logic [6:0]  a;
        int          n, r;
        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(0, 9));
            n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(5, 127));
            else                           a = 7'($urandom_range(0, 4));
            f = {($urandom_range(0, 5) != 0), a, 8'($urandom)};
            if (n == 17)      bits = {15'd0, f, 1'($urandom)};
            else if (n == 15) bits = {17'd0, f[15:1]};
            else              bits = {16'd0, f};
            spi_frame(bits, n);
            e = exp_out();
            m = exp_mask();
            checks++;
            if (({uio_out, uo_out} & m) !== (e & m)) begin
                failures++;
                $display("FAIL random_frame%0d frame=%h bits=%0d got=%h want=%h mask=%h",
                         k, f, n, {uio_out, uo_out}, e, m);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        sclk   = 1'b0;
        copi   = 1'b0;
        ncs    = 1'b1;
        model_reset();
        wait_clk(2);
        test_reset();
        test_basic_write();
        test_read_and_bad_addr();
        test_pwm_half();
        test_pwm_extremes();
        test_abort_and_overrun();
        test_reset_mid_frame();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
